// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - operand stream loader feeding the matrix_mult engine
//
// Purpose: accepts a row-major element stream over valid/ready, fills NxN
// buffer A then buffer B, pulses start for one cycle, then holds both
// buffers frozen until the engine's done level rises, and re-opens the stream.
//
// Optional feature macro: MATRIX_LOADER_FRAME_CHECK_EN (adds in_last/frame_err
// end-of-frame checking; without it framing is purely count based).
//
// Ports:
//   clk        in   single rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   element present on in_data
//   in_data    in   element value (DATA_WIDTH), A elements first then B
//   in_ready   out  loader accepts an element this cycle
//   A_flat     out  buffer A, element (r,c) at [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]
//   B_flat     out  buffer B, same layout
//   start      out  one-cycle compute request
//   done       in   engine completion level
//   busy       out  high while waiting on the engine (START, WAIT_DONE)
//   in_last    in   end-of-frame marker (frame check build only)
//   frame_err  out  sticky framing error (frame check build only)

module matrix_loader #(
    parameter int N          = 50,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic [N*N*DATA_WIDTH-1:0]    A_flat,
    output logic [N*N*DATA_WIDTH-1:0]    B_flat,
    output logic                         start,
    input  logic                         done,
    output logic                         busy
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
    ,
    input  logic                         in_last,
    output logic                         frame_err
`endif
);

    localparam int ELEMS = N * N;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT_DONE
    } state_t;

    state_t                      r_state;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_done_q;
    logic                        r_start;
    logic [ELEMS*DATA_WIDTH-1:0] r_a_flat;
    logic [ELEMS*DATA_WIDTH-1:0] r_b_flat;

    logic w_loading;
    logic w_xfer;
    logic w_last_idx;
    logic w_done_rise;
    int   w_base;

    // in_ready depends only on state and rst, never on in_valid.
    assign w_loading   = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign in_ready    = w_loading && !rst;
    assign w_xfer      = in_valid && in_ready;
    assign w_last_idx  = (r_idx == LAST_IDX);
    // A done level carried over from the previous run is already in r_done_q,
    // so only a fresh low-to-high transition ends the wait.
    assign w_done_rise = done && !r_done_q;
    assign w_base      = int'(r_idx) * DATA_WIDTH;

    assign A_flat = r_a_flat;
    assign B_flat = r_b_flat;
    assign start  = r_start;
    assign busy   = (r_state == START) || (r_state == WAIT_DONE);

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_frame_bad;

    // in_last must mark exactly the final B element.
    assign w_frame_bad = in_last != ((r_state == LOAD_B) && w_last_idx);
    assign frame_err   = r_frame_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD_A;
            r_idx    <= '0;
            r_done_q <= 1'b0;
            r_start  <= 1'b0;
            r_a_flat <= '0;
            r_b_flat <= '0;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_done_q <= done;
            r_start  <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (w_xfer) begin
                        r_a_flat[w_base +: DATA_WIDTH] <= in_data;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
                        if (w_frame_bad) begin
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                            r_state     <= LOAD_A;
                        end else
`endif
                        if (w_last_idx) begin
                            r_idx   <= '0;
                            r_state <= LOAD_B;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_xfer) begin
                        r_b_flat[w_base +: DATA_WIDTH] <= in_data;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
                        if (w_frame_bad) begin
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                            r_state     <= LOAD_A;
                        end else
`endif
                        if (w_last_idx) begin
                            r_idx   <= '0;
                            r_start <= 1'b1;
                            r_state <= START;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_state <= LOAD_A;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the `matrix_mult` engine. It accepts a row-major element stream over a valid/ready handshake and fills two NxN operand buffers, first A and then B. It then pulses `start` for one cycle and holds both buffers frozen until the engine reports completion. After completion it re-opens the stream for the next operand pair.

## Interface
- `N`, 50, matrix dimension; must match the downstream engine.
- `DATA_WIDTH`, 8, element bit-width.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an element is present on `in_data`.
- `in_data` input DATA_WIDTH: element value, row-major order, A elements first then B elements.
- `in_ready` output 1: loader can accept an element this cycle.
- `in_last` input 1: end-of-frame marker. Present only with `MATRIX_LOADER_FRAME_CHECK_EN`.
- `A_flat` output N*N*DATA_WIDTH: buffer A. Element (r,c) sits at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- `B_flat` output N*N*DATA_WIDTH: buffer B, same layout as `A_flat`.
- `start` output 1: one-cycle compute request to the engine.
- `done` input 1: engine completion level; goes high at the end of a run and stays high until the next start.
- `busy` output 1: high in states START and WAIT_DONE.
- `frame_err` output 1: sticky framing-error flag. Present only with `MATRIX_LOADER_FRAME_CHECK_EN`.

## Operation
- States: LOAD_A, LOAD_B, START, WAIT_DONE.
- Element index `idx` counts 0..N*N-1. Its width is $clog2(N*N), minimum 1 bit.
- A transfer occurs on a rising edge where `in_valid && in_ready`.
- LOAD_A: `in_ready`=1. Each transfer writes `in_data` into A[idx].
  - If idx==N*N-1: idx resets to 0 and the state moves to LOAD_B.
  - Otherwise idx increments by 1.
- LOAD_B: `in_ready`=1. Each transfer writes B[idx].
  - If idx==N*N-1: idx resets to 0 and the state moves to START.
- START: `in_ready`=0 and `start`=1 for exactly this one cycle. The state always advances to WAIT_DONE.
- WAIT_DONE: `in_ready`=0.
  - A register `done_q` holds the previous cycle's `done`.
  - The exit condition is a rising edge, `done && !done_q`. On that edge the state returns to LOAD_A.
  - A `done` level already high on entry (from the previous run) never ends the wait.
- Buffers change only on accepted transfers. A_flat/B_flat are stable throughout START and WAIT_DONE.
- No width conversion: `in_data` is stored verbatim.
- `in_valid` held high while `in_ready`=0 has no effect. Data is not sampled or queued.
- Reset values: state=LOAD_A, idx=0, done_q=0, all buffer bits 0, `start`=0, `busy`=0, `frame_err`=0. `in_ready` is forced 0 while `rst` is high.
- Reset mid-operation, in any state:
  - all of the above reset values are restored on the same edge;
  - partial loads are discarded;
  - no `start` is issued.

## Timing
- `start` is registered. If the final B element is accepted at edge E, `start` is high from E to E+1 and the state is WAIT_DONE from E+1.
- Minimum gap between the last accepted B element and the first accepted A element of the next frame: 3 cycles, plus the engine's latency to the `done` rise.
- If the `done` rise is sampled at edge D, `in_ready` is 1 in the cycle after D.
- Throughput while loading: one element per cycle. Load time is at least 2*N*N cycles.
- `in_ready` is a function of state and `rst` only. It has no combinational path from `in_valid`.

## Configuration
- `MATRIX_LOADER_FRAME_CHECK_EN` defined:
  - `in_last` and `frame_err` ports exist.
  - `in_last` must be 1 exactly on the final B element, and on no other element.
  - Violation cases: `in_last`=1 on an earlier element, or `in_last`=0 on the final element.
  - On a violation: the element is still written, `frame_err` is set and stays set, idx goes to 0, the state goes to LOAD_A, and no `start` is issued.
  - `frame_err` clears only on `rst`.
- `MATRIX_LOADER_FRAME_CHECK_EN` undefined:
  - `in_last` and `frame_err` ports are absent.
  - Framing is purely count-based.

## Test plan
- N=2, DATA_WIDTH=8, stream 1,2,3,4,5,6,7,8 back-to-back.
  - A elements (0,0)..(1,1) = 1,2,3,4; B elements = 5,6,7,8.
  - `start` pulses exactly once, in the cycle after the 8th accept.
  - With `matrix_mult` attached, C = 19,22,43,50.
- Backpressure: keep `in_valid`=1 with data 9 throughout WAIT_DONE.
  - No accepts and no buffer change.
  - After the `done` rise, 9 is written to A(0,0).
- Done-level check: hold `done`=1 from the previous run when entering WAIT_DONE.
  - The loader stays in WAIT_DONE until `done` goes low and then high again.
- Reset after 5 accepted elements (mid LOAD_B).
  - All buffer bits read 0 and idx is 0.
  - `in_ready` reads 0 during reset and 1 after it.
  - No `start` is issued.
- `in_valid` gaps: random idle cycles between elements give the same buffer contents and a single `start`.
- With `MATRIX_LOADER_FRAME_CHECK_EN`: `in_last`=1 on element 3.
  - `frame_err` reads 1 and no `start` is issued.
  - The next 8 elements with correct `in_last` load normally and `start` pulses.
  - `frame_err` remains 1.
